// File: rtl/rf_write_arbiter_if.sv
// Register-file write port bundle: pipeline writeback,
// long-latency results, and the arbitrated write port.
interface rf_write_arbiter_if #(
  parameter int RFW = 5,
  parameter int DW  = 32
);
  logic              wb_valid;
  logic [RFW-1:0]    wb_rd;
  logic [DW-1:0]     wb_data;
  logic              lu_valid;
  logic [RFW-1:0]    lu_rd;
  logic [DW-1:0]     lu_data;
  logic              lu_ready;
  logic              rf_we;
  logic [RFW-1:0]    wreg;
  logic [DW-1:0]     wdata;
  logic [2**RFW-1:0] pending_mask;
  logic              pipe_stall;
  logic              busy;

  modport master (
    output wb_valid, wb_rd, wb_data,
    output lu_valid, lu_rd, lu_data,
    input  lu_ready,
    input  rf_we, wreg, wdata,
    input  pending_mask, pipe_stall, busy
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  lu_valid, lu_rd, lu_data,
    output lu_ready,
    output rf_we, wreg, wdata,
    output pending_mask, pipe_stall, busy
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between writeback and a
// long-latency result FIFO. RF_CLEAR_SEQ_EN adds a post-reset x1..x31 clear.
module rf_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  parameter int RFW      = 5,
  parameter int DW       = 32
) (
  input logic               clk,
  input logic               rf_reset_n,
  rf_write_arbiter_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [AW-1:0]  rd_ptr_q;
  logic [AW-1:0]  wr_ptr_q;
  logic [CW-1:0]  cnt_q;
  logic           ent_v_q    [DEPTH];
  logic [RFW-1:0] ent_rd_q   [DEPTH];
  logic [DW-1:0]  ent_data_q [DEPTH];
  logic [WW-1:0]  wait_q;

  logic           rf_we_q;
  logic           rf_we_d;
  logic [RFW-1:0] wreg_q;
  logic [RFW-1:0] wreg_d;
  logic [DW-1:0]  wdata_q;
  logic [DW-1:0]  wdata_d;

  logic           run;
  logic           empty;
  logic           full;
  logic           head_v;
  logic           wb_hit;
  logic           head_pop;
  logic           head_wr;
  logic           lu_rdy;
  logic           enq;

`ifdef RF_CLEAR_SEQ_EN
  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t         state_q;
  logic [RFW-1:0] idx_q;
  logic           clr;

  assign run = (state_q == ST_RUN);
  assign clr = (state_q == ST_CLEAR);
`else
  assign run = 1'b1;
`endif

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign head_v = ent_v_q[rd_ptr_q];
  assign wb_hit = run & bus.wb_valid
                & (bus.wb_rd != '0);

  // A squashed head leaves without a write, so it
  // never needs the port and is popped regardless.
  assign head_pop = run & ~empty
                  & (~head_v | ~wb_hit);
  assign head_wr  = head_pop & head_v;

  assign lu_rdy = run & (~full | head_pop);
  assign enq    = bus.lu_valid & lu_rdy
                & (bus.lu_rd != '0);

  // Port grant: clear sequence, then writeback, then buffer head.
  always_comb begin
    rf_we_d = 1'b0;
    wreg_d  = '0;
    wdata_d = '0;
    unique case (1'b1)
`ifdef RF_CLEAR_SEQ_EN
      clr: begin
        rf_we_d = 1'b1;
        wreg_d  = idx_q;
      end
`endif
      wb_hit: begin
        rf_we_d = 1'b1;
        wreg_d  = bus.wb_rd;
        wdata_d = bus.wb_data;
      end
      head_wr: begin
        rf_we_d = 1'b1;
        wreg_d  = ent_rd_q[rd_ptr_q];
        wdata_d = ent_data_q[rd_ptr_q];
      end
      default: ;
    endcase
  end

  // Pending destinations of the still-valid buffered entries.
  always_comb begin
    bus.pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_v_q[i]) begin
        bus.pending_mask[ent_rd_q[i]] = 1'b1;
      end
    end
  end

  // Result FIFO: squash by writeback, pop at head, push at tail.
  always_ff @(posedge clk or negedge rf_reset_n) begin
    if (!rf_reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_v_q[i]    <= 1'b0;
        ent_rd_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_hit && ent_v_q[i]
            && ent_rd_q[i] == bus.wb_rd) begin
          ent_v_q[i] <= 1'b0;
        end
      end
      if (head_pop) begin
        ent_v_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + AW'(1);
      end
      if (enq) begin
        ent_v_q[wr_ptr_q]    <= 1'b1;
        ent_rd_q[wr_ptr_q]   <= bus.lu_rd;
        ent_data_q[wr_ptr_q] <= bus.lu_data;
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(enq) - CW'(head_pop);
    end
  end

  // Starvation counter: counts denied cycles, saturates.
  always_ff @(posedge clk or negedge rf_reset_n) begin
    if (!rf_reset_n) begin
      wait_q <= '0;
    end else if (empty || head_pop) begin
      wait_q <= '0;
    end else if (wait_q != WW'(MAX_WAIT)) begin
      wait_q <= wait_q + WW'(1);
    end
  end

  // Control FSM and registered write port.
  always_ff @(posedge clk or negedge rf_reset_n) begin
    if (!rf_reset_n) begin
      rf_we_q <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
`ifdef RF_CLEAR_SEQ_EN
      state_q <= ST_CLEAR;
      idx_q   <= RFW'(1);
`endif
    end else begin
      rf_we_q <= rf_we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
`ifdef RF_CLEAR_SEQ_EN
      unique case (state_q)
        ST_CLEAR: begin
          idx_q <= idx_q + RFW'(1);
          if (idx_q == '1) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: ;
        default: state_q <= ST_RUN;
      endcase
`endif
    end
  end

  assign bus.rf_we      = rf_we_q;
  assign bus.wreg       = wreg_q;
  assign bus.wdata      = wdata_q;
  assign bus.lu_ready   = lu_rdy;
  assign bus.pipe_stall = (wait_q == WW'(MAX_WAIT));
`ifdef RF_CLEAR_SEQ_EN
  assign bus.busy = clr;
`else
  assign bus.busy = 1'b0;
`endif

endmodule
